// File: rtl/mem_copy_pkg.sv
// Shared types and address map for the memory-copy bus initiator.
// Holds the FSM state encoding, error codes and the boot-time copy regions.
package mem_copy_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StFinish
    } state_e;

    typedef enum logic [1:0] {
        ErrNone    = 2'd0,
        ErrRead    = 2'd1,
        ErrWrite   = 2'd2,
        ErrTimeout = 2'd3
    } err_code_e;

    localparam logic [31:0] SRAM_BASE = 32'h0000_1000;
    localparam logic [31:0] SRAM_END  = 32'h0000_1FFF;
    localparam logic [31:0] EXT_BASE  = 32'h0000_2000;

    // Wraps modulo 2^32; running off the top of the map is left to the target to reject.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr,
                                                   input int unsigned bytes);
        return addr + 32'(bytes);
    endfunction

endpackage

// File: rtl/resp_timeout.sv
// Response watchdog: loadable down-counter that flags when a bus response is overdue.
// clear_i reloads the budget; en_i counts one waited cycle; expired_o marks the last one.
module resp_timeout #(
    parameter int unsigned Cycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);
    // Counts the waited cycles still allowed after the current one.
    localparam logic [CntW-1:0] LoadVal = CntW'(Cycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LoadVal;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= LoadVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_copy_initiator.sv
// Bus initiator that copies a block of words: one read, then one write, per word.
// Stops on the first bus error or response timeout and reports the failing address.
module mem_copy_initiator
    import mem_copy_pkg::*;
#(
    parameter int unsigned MEM_W          = 32,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [CNT_W-1:0]   word_count,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [31:0]        err_addr,
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    output logic               mem_we_o,
    output logic [MEM_W/8-1:0] mem_be_o,
    output logic [MEM_W-1:0]   mem_wdata_o,
    input  logic               mem_rvalid_i,
    input  logic               mem_err_i,
    input  logic [MEM_W-1:0]   mem_rdata_i
);

    localparam int unsigned BYTES = MEM_W / 8;

    state_e             state_q;
    logic [31:0]        src_q, dst_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               busy_q, done_q, error_q;
    err_code_e          err_code_q;
    logic [31:0]        err_addr_q;
    logic               req_q, we_q;
    logic [31:0]        addr_q;
    logic [BYTES-1:0]   be_q;
    logic [MEM_W-1:0]   wdata_q;

    logic tmo_clear, tmo_en, tmo_expired;

    // Budget is reloaded in each request cycle so every wait phase starts fresh.
    assign tmo_clear = (state_q == StRdReq) || (state_q == StWrReq);
    assign tmo_en    = (state_q == StRdWait) || (state_q == StWrWait);

    resp_timeout #(
        .Cycles (TIMEOUT_CYCLES)
    ) u_resp_timeout (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clear_i   (tmo_clear),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ErrNone;
            err_addr_q  <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q       <= src_addr;
                        dst_q       <= dst_addr;
                        remaining_q <= word_count;
                        busy_q      <= 1'b1;
                        error_q     <= 1'b0;
                        err_code_q  <= ErrNone;
                        err_addr_q  <= '0;
                        if (word_count == '0) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRdReq;
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= src_addr;
                            be_q    <= '1;
                        end
                    end
                end
                StRdReq: begin
                    req_q   <= 1'b0;
                    state_q <= StRdWait;
                end
                StRdWait: begin
                    if (mem_err_i) begin
                        state_q    <= StFinish;
                        done_q     <= 1'b1;
                        error_q    <= 1'b1;
                        err_code_q <= ErrRead;
                        err_addr_q <= addr_q;
                    end else if (mem_rvalid_i) begin
                        // The write-data register doubles as the captured read word.
                        wdata_q <= mem_rdata_i;
                        state_q <= StWrReq;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= dst_q;
                        be_q    <= '1;
                    end else if (tmo_expired) begin
                        state_q    <= StFinish;
                        done_q     <= 1'b1;
                        error_q    <= 1'b1;
                        err_code_q <= ErrTimeout;
                        err_addr_q <= addr_q;
                    end
                end
                StWrReq: begin
                    req_q   <= 1'b0;
                    state_q <= StWrWait;
                end
                StWrWait: begin
                    if (mem_err_i) begin
                        state_q    <= StFinish;
                        done_q     <= 1'b1;
                        error_q    <= 1'b1;
                        err_code_q <= ErrWrite;
                        err_addr_q <= addr_q;
                    end else if (mem_rvalid_i) begin
                        src_q       <= next_word_addr(src_q, BYTES);
                        dst_q       <= next_word_addr(dst_q, BYTES);
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRdReq;
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= next_word_addr(src_q, BYTES);
                            be_q    <= '1;
                        end
                    end else if (tmo_expired) begin
                        state_q    <= StFinish;
                        done_q     <= 1'b1;
                        error_q    <= 1'b1;
                        err_code_q <= ErrTimeout;
                        err_addr_q <= addr_q;
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign err_addr    = err_addr_q;
    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed + randomized bench for mem_copy_initiator against a bus target model
// and a transaction-level reference of the expected copy.
module tb_mem_copy_initiator;
    import mem_copy_pkg::*;

    localparam int unsigned T = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        t_rvalid = 1'b0;
    logic        t_err = 1'b0;
    logic [31:0] t_rdata = '0;

    always #5 clk = ~clk;

    mem_copy_initiator #(
        .MEM_W          (32),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .err_addr     (err_addr),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (t_rvalid),
        .mem_err_i    (t_err),
        .mem_rdata_i  (t_rdata)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        obs_q[$];
    logic [31:0] ext_mem[logic [31:0]];
    int          err_idx = -1;
    int          mute_idx = -1;
    bit          spur_rd = 1'b0;
    int          txn_n = 0;
    int          pend_idx = 0;
    int          cd = 0;
    int          stab_bad = 0;
    txn_t        pend;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (ext_mem.exists(a)) return ext_mem[a];
        return a ^ 32'h5A5A_F00D;
    endfunction

    // Target: answers each request 2 cycles later, optionally with err or not at all.
    initial begin : target
        txn_t t;
        forever begin
            @(posedge clk);
            #1;
            t_rvalid = 1'b0;
            t_err = 1'b0;
            if (!rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        if (mem_addr_o !== pend.addr || mem_we_o !== pend.we ||
                            mem_be_o !== 4'hF || (pend.we && mem_wdata_o !== pend.wdata))
                            stab_bad++;
                        if (pend_idx == err_idx) begin
                            t_err = 1'b1;
                            t_rvalid = 1'($urandom_range(0, 1));
                        end else begin
                            t_rvalid = 1'b1;
                        end
                        t_rdata = pend.we ? $urandom : rd(pend.addr);
                    end
                end
                if (mem_req_o === 1'b1) begin
                    t.addr = mem_addr_o;
                    t.we = mem_we_o;
                    t.wdata = mem_wdata_o;
                    t.be = mem_be_o;
                    obs_q.push_back(t);
                    pend = t;
                    pend_idx = txn_n;
                    txn_n++;
                    if (pend_idx != mute_idx) cd = 2;
                    if (spur_rd && !mem_we_o) begin
                        t_rvalid = 1'b1;
                        t_rdata = 32'hDEAD_BEEF;
                    end
                end
            end
        end
    end

    task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int n, input int errk, input int mutek,
                            input bit spur, input bit poke);
        txn_t        e;
        txn_t        exp_q[$];
        int          k = 0;
        int          exp_lat = 1;
        logic [1:0]  exp_code = 2'd0;
        logic [31:0] exp_addr = '0;
        bit          stop = 1'b0;
        int          lat;
        int          busy_drop = 0;
        // Reference: read i then write i, stopping at the first faulty transaction.
        for (int i = 0; i < n && !stop; i++) begin
            for (int w = 0; w < 2 && !stop; w++) begin
                e.we = (w == 1);
                e.addr = e.we ? dst + 32'(4 * i) : src + 32'(4 * i);
                e.wdata = rd(src + 32'(4 * i));
                e.be = 4'hF;
                exp_q.push_back(e);
                if (k == errk) begin
                    stop = 1'b1;
                    exp_code = e.we ? 2'd2 : 2'd1;
                    exp_addr = e.addr;
                    exp_lat = 3 * (k + 1) + 1;
                end else if (k == mutek) begin
                    stop = 1'b1;
                    exp_code = 2'd3;
                    exp_addr = e.addr;
                    exp_lat = 3 * k + 2 + T;
                end
                k++;
            end
        end
        if (!stop && n > 0) exp_lat = 3 * k + 1;

        obs_q.delete();
        txn_n = 0;
        err_idx = errk;
        mute_idx = mutek;
        spur_rd = spur;
        stab_bad = 0;

        @(negedge clk);
        src_addr = src;
        dst_addr = dst;
        word_count = 16'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        word_count = 16'($urandom);
        lat = 1;
        check($sformatf("%s.err_cleared", tag), 32'(error), 32'd0);
        while (done !== 1'b1 && lat < exp_lat + 8) begin
            if (busy !== 1'b1) busy_drop++;
            if (poke && lat == 2) begin
                start = 1'b1;
                src_addr = 32'h0000_3000;
                word_count = 16'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check($sformatf("%s.done_lat", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s.busy_at_done", tag), 32'(busy), 32'd1);
        check($sformatf("%s.error", tag), 32'(error), 32'(exp_code != 2'd0));
        check($sformatf("%s.err_code", tag), 32'(err_code), 32'(exp_code));
        check($sformatf("%s.err_addr", tag), err_addr, exp_addr);
        check($sformatf("%s.busy_drop", tag), 32'(busy_drop), 32'd0);
        @(negedge clk);
        check($sformatf("%s.done_pulse", tag), 32'(done), 32'd0);
        check($sformatf("%s.busy_after", tag), 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check($sformatf("%s.error_sticky", tag), 32'(error), 32'(exp_code != 2'd0));
        check($sformatf("%s.n_txn", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
            check($sformatf("%s.t%0d.addr", tag, j), obs_q[j].addr, exp_q[j].addr);
            check($sformatf("%s.t%0d.we", tag, j), 32'(obs_q[j].we), 32'(exp_q[j].we));
            check($sformatf("%s.t%0d.be", tag, j), 32'(obs_q[j].be), 32'(exp_q[j].be));
            if (exp_q[j].we)
                check($sformatf("%s.t%0d.wdata", tag, j), obs_q[j].wdata, exp_q[j].wdata);
        end
        check($sformatf("%s.hold_stable", tag), 32'(stab_bad), 32'd0);
    endtask

    initial begin : main
        int n, ek, w;
        logic [31:0] s, d;
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.error", 32'(error), 32'd0);
        check("rst.err_code", 32'(err_code), 32'd0);
        check("rst.err_addr", err_addr, 32'd0);
        check("rst.req", 32'(mem_req_o), 32'd0);
        check("rst.we", 32'(mem_we_o), 32'd0);
        check("rst.addr", mem_addr_o, 32'd0);
        check("rst.be", 32'(mem_be_o), 32'd0);
        check("rst.wdata", mem_wdata_o, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) ext_mem[EXT_BASE + 32'(4 * i)] = 32'hA0 + 32'(i);
        run_copy("copy4", EXT_BASE, SRAM_BASE, 4, -1, -1, 1'b0, 1'b0);
        run_copy("zero", EXT_BASE, SRAM_BASE, 0, -1, -1, 1'b0, 1'b0);
        run_copy("wr_err", EXT_BASE + 32'h40, SRAM_BASE, 3, 3, -1, 1'b0, 1'b0);
        run_copy("rd_err", EXT_BASE + 32'h80, SRAM_BASE + 32'h20, 3, 2, -1, 1'b0, 1'b0);
        run_copy("timeout", 32'h0000_0105, SRAM_BASE, 1, -1, 0, 1'b0, 1'b0);
        run_copy("poke", EXT_BASE + 32'h100, SRAM_BASE + 32'h100, 3, -1, -1, 1'b1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 5);
            s = EXT_BASE + 32'(4 * $urandom_range(0, 255));
            d = SRAM_BASE + 32'(4 * $urandom_range(0, int'((SRAM_END - SRAM_BASE + 1) / 4) - 8));
            ek = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
            run_copy($sformatf("rand%0d", r), s, d, n, ek, -1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while the first write is outstanding.
        obs_q.delete();
        txn_n = 0;
        err_idx = -1;
        mute_idx = -1;
        spur_rd = 1'b0;
        @(negedge clk);
        src_addr = EXT_BASE;
        dst_addr = SRAM_BASE + 32'h800;
        word_count = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (txn_n < 2 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("mid_rst.reached_write", 32'(txn_n >= 2), 32'd1);
        @(posedge clk);
        #2;
        check("mid_rst.busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst.busy", 32'(busy), 32'd0);
        check("mid_rst.req", 32'(mem_req_o), 32'd0);
        check("mid_rst.we", 32'(mem_we_o), 32'd0);
        check("mid_rst.addr", mem_addr_o, 32'd0);
        check("mid_rst.wdata", mem_wdata_o, 32'd0);
        w = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) w++;
        end
        check("mid_rst.no_done", 32'(w), 32'd0);
        rst = 1'b1;
        run_copy("after_rst", EXT_BASE + 32'h20, SRAM_BASE + 32'h40, 2, -1, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
